// File: rtl/mux_stream_sel.sv
// N:1 registered mux with valid/ready output, single-read and scan modes.
// Optional argmax tracker over scan beats: define MUX_STREAM_ARGMAX_EN.
module mux_stream_sel #(
  parameter int N  = 16,
  parameter int W  = 16,
  parameter int SW = (N > 2) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] din,
  input  logic [SW-1:0]  sel,
  input  logic           scan,
  input  logic           req_valid,
  output logic           req_ready,
  output logic [W-1:0]   dout,
  output logic [SW-1:0]  dout_idx,
  output logic           dout_last,
  output logic           dout_valid,
  input  logic           dout_ready,
  output logic           busy,
  output logic [W-1:0]   max_val,
  output logic [SW-1:0]  max_idx,
  output logic           max_valid
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  localparam logic [SW-1:0] LASTI = SW'(N - 1);

  state_t        state;
  state_t        state_nx;
  logic [SW-1:0] cnt;
  logic [SW-1:0] cnt_nx;
  logic          can_load;
  logic          do_load;
  logic          last_nx;
  logic          sel_ok;
  logic [SW-1:0] ld_idx;
  logic [W-1:0]  ld_dat;

  assign can_load = ~dout_valid | dout_ready;
  assign sel_ok   = int'(sel) < N;
  assign busy     = (state == SCAN);

  // Next-state, handshake and slot-load decode
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    req_ready = 1'b0;
    do_load   = 1'b0;
    ld_idx    = '0;
    last_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = can_load;
        if (req_valid && can_load) begin
          do_load = 1'b1;
          if (scan) begin
            ld_idx   = '0;
            last_nx  = 1'b0;
            state_nx = SCAN;
            cnt_nx   = SW'(1);
          end else begin
            ld_idx  = sel_ok ? sel : '0;
            last_nx = 1'b1;
          end
        end
      end
      SCAN: begin
        if (can_load) begin
          do_load = 1'b1;
          ld_idx  = cnt;
          last_nx = (cnt == LASTI);
          if (cnt == LASTI) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + SW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Channel mux for the index being loaded
  always_comb begin
    ld_dat = '0;
    for (int k = 0; k < N; k++) begin
      if (ld_idx == SW'(k)) ld_dat = din[k*W +: W];
    end
  end

  // FSM state and scan counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Output slot: refill on load, drain when consumed with nothing new
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_idx   <= '0;
      dout_last  <= 1'b0;
      dout_valid <= 1'b0;
    end else if (do_load) begin
      dout       <= ld_dat;
      dout_idx   <= ld_idx;
      dout_last  <= last_nx;
      dout_valid <= 1'b1;
    end else if (can_load) begin
      dout_valid <= 1'b0;
    end
  end

`ifdef MUX_STREAM_ARGMAX_EN
  logic [W-1:0]  run_val;
  logic [SW-1:0] run_idx;
  logic          scan_ld;
  logic          take;

  assign scan_ld = do_load & ((state == SCAN) | scan);
  assign take    = (ld_idx == '0) | (ld_dat > run_val);

  // Running argmax over scan beats; strict compare keeps lower index on ties
  always_ff @(posedge clk) begin
    if (rst) begin
      run_val   <= '0;
      run_idx   <= '0;
      max_val   <= '0;
      max_idx   <= '0;
      max_valid <= 1'b0;
    end else begin
      max_valid <= 1'b0;
      if (scan_ld) begin
        if (take) begin
          run_val <= ld_dat;
          run_idx <= ld_idx;
        end
        if (last_nx) begin
          max_val   <= take ? ld_dat : run_val;
          max_idx   <= take ? ld_idx : run_idx;
          max_valid <= 1'b1;
        end
      end
    end
  end
`else
  assign max_val   = '0;
  assign max_idx   = '0;
  assign max_valid = 1'b0;
`endif

endmodule

// File: tb/tb_mux_stream_sel.sv
// Bench for mux_stream_sel: queue-based reference model plus directed checks.
// Argmax expectations follow MUX_STREAM_ARGMAX_EN when defined.
module tb_mux_stream_sel;

  localparam int N  = 16;
  localparam int W  = 16;
  localparam int SW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] din;
  logic [SW-1:0]  sel;
  logic           scan;
  logic           req_valid;
  logic           req_ready;
  logic [W-1:0]   dout;
  logic [SW-1:0]  dout_idx;
  logic           dout_last;
  logic           dout_valid;
  logic           dout_ready;
  logic           busy;
  logic [W-1:0]   max_val;
  logic [SW-1:0]  max_idx;
  logic           max_valid;

  int tests = 0;
  int fails = 0;

  mux_stream_sel #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .scan(scan),
    .req_valid(req_valid), .req_ready(req_ready),
    .dout(dout), .dout_idx(dout_idx), .dout_last(dout_last),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy),
    .max_val(max_val), .max_idx(max_idx), .max_valid(max_valid)
  );

  always #5 clk = ~clk;

  task automatic check(string nm, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // reference model: pending beat queue plus one output slot
  int           q[$];
  bit           run = 0;
  bit           sv;
  logic [W-1:0] sd;
  int           si;
  bit           sl;
  logic [W-1:0] scanv[N];
  bit           mv;
  logic [W-1:0] mval;
  int           midx;
  bit           can;
  bit           acc;

  function automatic logic [W-1:0] ch(int k);
    return din[k*W +: W];
  endfunction

  function automatic bit m_rdy();
    return (q.size() == 0) && (!sv || dout_ready);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      run = 1;
      sv = 0; sd = '0; si = 0; sl = 0;
      mv = 0; mval = '0; midx = 0;
    end else if (run) begin
      can = !sv || dout_ready;
      acc = req_valid && m_rdy();
      mv = 0;
      if (can) begin
        if (acc && scan)
          for (int k = 0; k < N; k++) q.push_back(k);
        if (q.size() > 0) begin
          si = q.pop_front();
          sd = ch(si);
          sl = (si == N - 1);
          sv = 1;
          scanv[si] = sd;
`ifdef MUX_STREAM_ARGMAX_EN
          if (sl) begin
            mval = scanv[0];
            midx = 0;
            for (int k = 1; k < N; k++)
              if (scanv[k] > mval) begin
                mval = scanv[k];
                midx = k;
              end
            mv = 1;
          end
`endif
        end else if (acc) begin
          si = int'(sel);
          sd = ch(si);
          sl = 1;
          sv = 1;
        end else begin
          sv = 0;
        end
      end
    end
  end

  // compare process: every cycle once the model has seen reset
  always @(negedge clk) begin
    if (run) begin
      check("m_valid", 32'(dout_valid), 32'(sv));
      if (sv) begin
        check("m_dout", 32'(dout), 32'(sd));
        check("m_idx", 32'(dout_idx), si);
        check("m_last", 32'(dout_last), 32'(sl));
      end
      check("m_req_ready", 32'(req_ready), 32'(m_rdy()));
      check("m_busy", 32'(busy), 32'(q.size() > 0));
      check("m_max_valid", 32'(max_valid), 32'(mv));
      check("m_max_val", 32'(max_val), 32'(mval));
      check("m_max_idx", 32'(max_idx), midx);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic din_default();
    for (int k = 0; k < N; k++) din[k*W +: W] = 16'h0100 + 16'(k);
  endtask

  int  exp_i;
  int  cnt_mv;
  bit  hit;

  initial begin
    rst = 1; req_valid = 0; scan = 0; sel = '0; dout_ready = 1;
    din_default();
    tick();
    tick();
    check("rst_dout", 32'(dout), 0);
    check("rst_valid", 32'(dout_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_max", 32'(max_val), 0);
    rst = 0;

    // single read
    req_valid = 1; sel = 4'd5;
    tick();
    req_valid = 0;
    check("t1_dout", 32'(dout), 32'h0105);
    check("t1_idx", 32'(dout_idx), 5);
    check("t1_last", 32'(dout_last), 1);
    check("t1_valid", 32'(dout_valid), 1);
    tick();

    // back-to-back singles
    req_valid = 1; sel = 4'd3;
    check("t2_rdy0", 32'(req_ready), 1);
    tick();
    check("t2_d0", 32'(dout), 32'h0103);
    check("t2_rdy1", 32'(req_ready), 1);
    sel = 4'd7;
    tick();
    check("t2_d1", 32'(dout), 32'h0107);
    check("t2_rdy2", 32'(req_ready), 1);
    sel = 4'd15;
    tick();
    check("t2_d2", 32'(dout), 32'h010F);
    req_valid = 0;
    tick();

    // full scan at full rate
    req_valid = 1; scan = 1;
    tick();
    req_valid = 0; scan = 0;
    for (int b = 0; b < N; b++) begin
      check("t3_valid", 32'(dout_valid), 1);
      check("t3_idx", 32'(dout_idx), b);
      check("t3_dout", 32'(dout), 32'h0100 + b);
      check("t3_last", 32'(dout_last), 32'(b == N - 1));
      check("t3_busy", 32'(busy), 32'(b != N - 1));
      check("t3_rdy", 32'(req_ready), 32'(b == N - 1));
      tick();
    end
    check("t3_drained", 32'(dout_valid), 0);

    // scan with a 3-cycle stall on beat 2
    req_valid = 1; scan = 1;
    tick();
    req_valid = 0; scan = 0;
    exp_i = 0;
    for (int c = 0; c < 40 && exp_i < N; c++) begin
      dout_ready = !(c >= 2 && c <= 4);
      if (!dout_ready) check("t4_hold", 32'(dout_idx), 2);
      if (dout_valid && dout_ready) begin
        check("t4_seq", 32'(dout_idx), exp_i);
        exp_i++;
      end
      tick();
    end
    dout_ready = 1;
    check("t4_beats", exp_i, N);
    tick();

    // argmax with a tie between channels 9 and 12
    for (int k = 0; k < N; k++) din[k*W +: W] = 16'h0010 + 16'(k);
    din[9*W +: W] = 16'hFFF0;
    din[12*W +: W] = 16'hFFF0;
    req_valid = 1; scan = 1;
    tick();
    req_valid = 0; scan = 0;
    cnt_mv = 0;
    for (int c = 0; c < 24; c++) begin
      if (max_valid) begin
        cnt_mv++;
        check("t5_coincide", 32'(dout_last && dout_valid), 1);
        check("t5_val", 32'(max_val), 32'hFFF0);
        check("t5_idx", 32'(max_idx), 9);
      end
      tick();
    end
`ifdef MUX_STREAM_ARGMAX_EN
    check("t5_pulses", cnt_mv, 1);
`else
    check("t5_pulses", cnt_mv, 0);
    check("t5_tied", 32'(max_val), 0);
`endif
    din_default();

    // reset mid-scan
    req_valid = 1; scan = 1;
    tick();
    req_valid = 0; scan = 0;
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (dout_valid && dout_idx == 4'd6) hit = 1;
      else tick();
    end
    check("t6_reach6", 32'(hit), 1);
    rst = 1;
    tick();
    rst = 0;
    check("t6_dout", 32'(dout), 0);
    check("t6_idx", 32'(dout_idx), 0);
    check("t6_last", 32'(dout_last), 0);
    check("t6_valid", 32'(dout_valid), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_mv", 32'(max_valid), 0);
    check("t6_rdy", 32'(req_ready), 1);
    req_valid = 1; sel = 4'd1;
    tick();
    req_valid = 0;
    check("t6_dout1", 32'(dout), 32'h0101);
    check("t6_idx1", 32'(dout_idx), 1);
    tick();

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < N; k++) din[k*W +: W] = W'($urandom);
      req_valid  = ($urandom_range(1) == 1);
      scan       = ($urandom_range(7) == 0);
      sel        = SW'($urandom_range(N - 1));
      dout_ready = ($urandom_range(3) != 0);
      rst        = ($urandom_range(299) == 0);
      tick();
    end
    rst = 0; req_valid = 0; dout_ready = 1;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
